cond_logic: RTL and testbench
=============================

Name: cond_logic

Overview:
- Sits directly downstream of the ALU in the single-cycle core and consumes its 4-bit NZCV flag vector.
- Holds the architectural flag register and evaluates the 4-bit instruction condition field against the current flags.
- Gates the decoder's pc_s, reg_w and mem_w strobes, so that only instructions whose condition passes can change architectural state.
- Updates the flag register per instruction, in two independently write-enabled groups.

Parameters:
- NV_EXECUTES, 0, when 1 the condition code 4'b1111 passes unconditionally; when 0 it never passes.

Ports:
- clk  input  1  core clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous active-low reset.
- en  input  1  instruction valid / not stalled; when 0 no state changes and all gated strobes are 0.
- cond  input  4  instruction condition field.
- alu_flags  input  4  flags from the ALU: [3]=N, [2]=Z, [1]=C, [0]=V.
- flag_w  input  2  flag write enables: [1] writes N,Z; [0] writes C,V.
- pc_s  input  1  decoder request to write the PC.
- reg_w  input  1  decoder request to write the register file.
- mem_w  input  1  decoder request to write memory.
- pc_src  output  1  gated pc_s.
- reg_write  output  1  gated reg_w.
- mem_write  output  1  gated mem_w.
- cond_ex  output  1  condition passed for the current instruction.
- flags  output  4  architectural flag register, same bit order as alu_flags.

Behaviour:
- Reset: while reset_n=0, flags=4'b0000, asynchronously. All outputs are then derived from the reset flags; they are not separately registered.
- cond_ex is combinational from cond and the registered flags only. It never depends on alu_flags of the same instruction, so an instruction cannot condition on its own result.
- Condition table (pass when):
  - 0000 EQ: Z
  - 0001 NE: !Z
  - 0010 CS: C
  - 0011 CC: !C
  - 0100 MI: N
  - 0101 PL: !N
  - 0110 VS: V
  - 0111 VC: !V
  - 1000 HI: C & !Z
  - 1001 LS: !C | Z
  - 1010 GE: N==V
  - 1011 LT: N!=V
  - 1100 GT: !Z & (N==V)
  - 1101 LE: Z | (N!=V)
  - 1110 AL: 1
  - 1111 NV: NV_EXECUTES
- Output gating, combinational, zero latency: pc_src=en&cond_ex&pc_s; reg_write=en&cond_ex&reg_w; mem_write=en&cond_ex&mem_w.
- Flag write at the rising edge of clk when en & cond_ex:
  - flag_w[1]=1: flags[3:2] <= alu_flags[3:2].
  - flag_w[0]=1: flags[1:0] <= alu_flags[1:0].
  - Each group is independent. flag_w=2'b11 updates all four bits; 2'b00 holds all four.
- Failed condition or en=0: the flag register holds regardless of flag_w.
- New flag values are visible to cond_ex of the next instruction, one cycle later.
- alu_flags are taken bit-for-bit. No reinterpretation of the carry polarity is done here; carry semantics are owned by the ALU.
- Reset asserted mid-cycle clears the flags immediately. An edge coinciding with reset_n=0 performs no write.
- Unknown values on inputs with en=0 must not corrupt the flag register.

Decomposition:
- Shared package:
  - localparams for the 16 condition codes (COND_EQ … COND_NV).
  - flag bit indices FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
  - flag_w group encodings (FW_NZ=2'b10, FW_CV=2'b01).
- One natural sub-module: cond_check, purely combinational, with inputs cond[3:0], flags[3:0] and output cond_ex. It is instanced once; the parent holds the flag registers and the gating.

Test Plan:
- Reset: drive reset_n=0 mid-cycle after flags were loaded to 4'b1111 -> flags=0 immediately; cond=EQ gives cond_ex=0; cond=NE gives cond_ex=1 and reg_write=reg_w.
- Full update with AL: en=1, cond=1110, flag_w=11, alu_flags=4'b0100 -> next cycle flags=4'b0100; cond=EQ passes; cond=NE with reg_w=1 gives reg_write=0.
- Split groups: flags=0000; apply flag_w=01 with alu_flags=1111 -> flags=0011; then flag_w=10 with alu_flags=1000 -> flags=1011.
- Failed condition: flags=0000, cond=EQ, flag_w=11, alu_flags=1111, pc_s=reg_w=mem_w=1 -> all three gated outputs 0; flags stay 0000 next cycle.
- Signed/unsigned sweep: for each of the 16 flag values, step cond through 0–15 and compare cond_ex with a reference model. Spot checks:
  - N=1, V=0: LT=1, GE=0.
  - C=1, Z=0: HI=1.
  - cond=1111 gives 0 with NV_EXECUTES=0 and 1 with NV_EXECUTES=1.
- Stall: en=0, cond=AL, flag_w=11, alu_flags=1010 -> flags unchanged and all gated strobes 0. Raise en=1 on the next cycle -> flags=1010 after the edge.

Source files
------------

// File: rtl/cond_logic_pkg.sv
// Shared definitions for the condition/flag block: condition codes,
// NZCV bit positions and flag-write group encodings.
package cond_logic_pkg;

   localparam logic [3:0] COND_EQ = 4'b0000;
   localparam logic [3:0] COND_NE = 4'b0001;
   localparam logic [3:0] COND_CS = 4'b0010;
   localparam logic [3:0] COND_CC = 4'b0011;
   localparam logic [3:0] COND_MI = 4'b0100;
   localparam logic [3:0] COND_PL = 4'b0101;
   localparam logic [3:0] COND_VS = 4'b0110;
   localparam logic [3:0] COND_VC = 4'b0111;
   localparam logic [3:0] COND_HI = 4'b1000;
   localparam logic [3:0] COND_LS = 4'b1001;
   localparam logic [3:0] COND_GE = 4'b1010;
   localparam logic [3:0] COND_LT = 4'b1011;
   localparam logic [3:0] COND_GT = 4'b1100;
   localparam logic [3:0] COND_LE = 4'b1101;
   localparam logic [3:0] COND_AL = 4'b1110;
   localparam logic [3:0] COND_NV = 4'b1111;

   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

   localparam logic [1:0] FW_NZ = 2'b10;
   localparam logic [1:0] FW_CV = 2'b01;

endpackage

// File: rtl/cond_check.sv
// Combinational condition evaluator: decides whether an instruction's
// condition field passes against the architectural NZCV flags.
module cond_check
   import cond_logic_pkg::*;
#(
   parameter int NV_EXECUTES = 0
) (
   input  logic [3:0] cond,
   input  logic [3:0] flags,
   output logic       cond_ex
);

   logic n_f, z_f, c_f, v_f;

   assign n_f = flags[FLAG_N];
   assign z_f = flags[FLAG_Z];
   assign c_f = flags[FLAG_C];
   assign v_f = flags[FLAG_V];

   always_comb begin
      cond_ex = 1'b0;
      case (cond)
         COND_EQ: cond_ex = z_f;
         COND_NE: cond_ex = !z_f;
         COND_CS: cond_ex = c_f;
         COND_CC: cond_ex = !c_f;
         COND_MI: cond_ex = n_f;
         COND_PL: cond_ex = !n_f;
         COND_VS: cond_ex = v_f;
         COND_VC: cond_ex = !v_f;
         COND_HI: cond_ex = c_f & !z_f;
         COND_LS: cond_ex = !c_f | z_f;
         COND_GE: cond_ex = (n_f == v_f);
         COND_LT: cond_ex = (n_f != v_f);
         COND_GT: cond_ex = !z_f & (n_f == v_f);
         COND_LE: cond_ex = z_f | (n_f != v_f);
         COND_AL: cond_ex = 1'b1;
         default: cond_ex = (NV_EXECUTES != 0);
      endcase
   end

endmodule

// File: rtl/cond_logic.sv
// Architectural NZCV flag register plus condition gating of the decoder's
// state-changing strobes.
module cond_logic
   import cond_logic_pkg::*;
#(
   parameter int NV_EXECUTES = 0
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       en,
   input  logic [3:0] cond,
   input  logic [3:0] alu_flags,
   input  logic [1:0] flag_w,
   input  logic       pc_s,
   input  logic       reg_w,
   input  logic       mem_w,
   output logic       pc_src,
   output logic       reg_write,
   output logic       mem_write,
   output logic       cond_ex,
   output logic [3:0] flags
);

   logic commit;

   // cond_ex looks only at the registered flags, never at alu_flags, so an
   // instruction cannot condition on its own result.
   cond_check #(
      .NV_EXECUTES(NV_EXECUTES)
   ) u_cond_check (
      .cond    (cond),
      .flags   (flags),
      .cond_ex (cond_ex)
   );

   // en is the instruction-valid qualifier; there is no ready side, an
   // instruction with en=1 and a passing condition commits on the next edge.
   assign commit    = en & cond_ex;
   assign pc_src    = commit & pc_s;
   assign reg_write = commit & reg_w;
   assign mem_write = commit & mem_w;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         flags <= 4'b0000;
      end else if (commit) begin
         if ((flag_w & FW_NZ) != 2'b00)
            flags[FLAG_N:FLAG_Z] <= alu_flags[FLAG_N:FLAG_Z];
         if ((flag_w & FW_CV) != 2'b00)
            flags[FLAG_C:FLAG_V] <= alu_flags[FLAG_C:FLAG_V];
      end
   end

endmodule

// File: tb/tb_cond_logic.sv
// Bench for cond_logic: two instances (NV never / NV always) driven in
// parallel, checked against a table-driven flag model every cycle.
`timescale 1ns/1ps
module tb_cond_logic;

   logic       clk;
   logic       reset_n;
   logic       en;
   logic [3:0] cond;
   logic [3:0] alu_flags;
   logic [1:0] flag_w;
   logic       pc_s, reg_w, mem_w;

   logic       pc_src0, reg_write0, mem_write0, cond_ex0;
   logic [3:0] flags0;
   logic       pc_src1, reg_write1, mem_write1, cond_ex1;
   logic [3:0] flags1;

   int tests;
   int fails;
   bit cmp_on;

   logic [3:0] m_flags [2];

   cond_logic #(.NV_EXECUTES(0)) dut0 (
      .clk(clk), .reset_n(reset_n), .en(en), .cond(cond), .alu_flags(alu_flags),
      .flag_w(flag_w), .pc_s(pc_s), .reg_w(reg_w), .mem_w(mem_w),
      .pc_src(pc_src0), .reg_write(reg_write0), .mem_write(mem_write0),
      .cond_ex(cond_ex0), .flags(flags0)
   );

   cond_logic #(.NV_EXECUTES(1)) dut1 (
      .clk(clk), .reset_n(reset_n), .en(en), .cond(cond), .alu_flags(alu_flags),
      .flag_w(flag_w), .pc_s(pc_s), .reg_w(reg_w), .mem_w(mem_w),
      .pc_src(pc_src1), .reg_write(reg_write1), .mem_write(mem_write1),
      .cond_ex(cond_ex1), .flags(flags1)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #10 clk = ~clk;
   end

   // Odd codes are the negation of the preceding even code; 1111 is special.
   function automatic logic model_pass(input logic [3:0] c, input logic [3:0] f, input bit nv);
      bit n, z, cy, v, base;
      n = f[3]; z = f[2]; cy = f[1]; v = f[0];
      if (c == 4'b1111) return nv;
      case (c[3:1])
         3'd0: base = z;
         3'd1: base = cy;
         3'd2: base = n;
         3'd3: base = v;
         3'd4: base = cy && !z;
         3'd5: base = (n == v);
         3'd6: base = !z && (n == v);
         default: base = 1'b1;
      endcase
      return c[0] ? !base : base;
   endfunction

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_flags[0] <= 4'b0000;
         m_flags[1] <= 4'b0000;
      end else begin
         for (int k = 0; k < 2; k++) begin
            if (en && model_pass(cond, m_flags[k], k == 1))
               m_flags[k] <= {flag_w[1] ? alu_flags[3:2] : m_flags[k][3:2],
                              flag_w[0] ? alu_flags[1:0] : m_flags[k][1:0]};
         end
      end
   end

   task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   // scoreboard: every negedge, both instances against the model
   always @(negedge clk) begin
      if (cmp_on) begin
         for (int k = 0; k < 2; k++) begin
            logic p;
            logic [3:0] act, exp;
            p = model_pass(cond, m_flags[k], k == 1);
            exp = {m_flags[k]};
            act = (k == 0) ? flags0 : flags1;
            check($sformatf("flags[dut%0d]", k), act, exp);
            act = (k == 0) ? {cond_ex0, pc_src0, reg_write0, mem_write0}
                           : {cond_ex1, pc_src1, reg_write1, mem_write1};
            exp = {p, en & p & pc_s, en & p & reg_w, en & p & mem_w};
            check($sformatf("ex_pc_rw_mw[dut%0d]", k), act, exp);
         end
      end
   end

   // driver tasks
   task automatic drive(input logic e, input logic [3:0] c, input logic [1:0] fw,
                        input logic [3:0] alu, input logic [2:0] strobes);
      en = e; cond = c; flag_w = fw; alu_flags = alu;
      {pc_s, reg_w, mem_w} = strobes;
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic load(input logic [3:0] f);
      drive(1'b1, 4'b1110, 2'b11, f, 3'b000);
      step();
   endtask

   initial begin
      tests = 0; fails = 0; cmp_on = 1'b0;
      reset_n = 1'b0;
      drive(1'b0, 4'b0000, 2'b00, 4'b0000, 3'b000);
      #1 cmp_on = 1'b1;
      step(); step();
      check("reset_flags", flags0, 4'b0000);
      check("reset_eq", {3'b000, cond_ex0}, 4'b0000);
      reset_n = 1'b1;

      // mid-cycle reset after loading 1111
      load(4'b1111);
      check("load_1111", flags0, 4'b1111);
      reset_n = 1'b0;
      #1 check("async_clear0", flags0, 4'b0000);
      check("async_clear1", flags1, 4'b0000);
      drive(1'b1, 4'b0000, 2'b11, 4'b1111, 3'b000);
      #1 check("rst_eq", {3'b000, cond_ex0}, 4'b0000);
      drive(1'b1, 4'b0001, 2'b11, 4'b1111, 3'b010);
      #1 check("rst_ne", {2'b00, cond_ex0, reg_write0}, 4'b0011);
      step();
      check("edge_in_reset", flags0, 4'b0000);
      reset_n = 1'b1;

      // full update with AL
      drive(1'b1, 4'b1110, 2'b11, 4'b0100, 3'b000);
      step();
      check("al_update", flags0, 4'b0100);
      drive(1'b1, 4'b0000, 2'b00, 4'b0000, 3'b000);
      #1 check("eq_after", {3'b000, cond_ex0}, 4'b0001);
      drive(1'b1, 4'b0001, 2'b00, 4'b0000, 3'b010);
      #1 check("ne_gated", {2'b00, cond_ex0, reg_write0}, 4'b0000);

      // split groups
      load(4'b0000);
      drive(1'b1, 4'b1110, 2'b01, 4'b1111, 3'b000);
      step();
      check("split_cv", flags0, 4'b0011);
      drive(1'b1, 4'b1110, 2'b10, 4'b1000, 3'b000);
      step();
      check("split_nz", flags0, 4'b1011);

      // failed condition
      load(4'b0000);
      drive(1'b1, 4'b0000, 2'b11, 4'b1111, 3'b111);
      #1 check("fail_gates", {1'b0, pc_src0, reg_write0, mem_write0}, 4'b0000);
      step();
      check("fail_hold", flags0, 4'b0000);

      // condition sweep over every flag value
      for (int f = 0; f < 16; f++) begin
         load(f[3:0]);
         for (int c = 0; c < 16; c++) begin
            drive(1'b1, c[3:0], 2'b00, 4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)));
            #1 check("sweep", {3'b000, cond_ex0}, {3'b000, model_pass(c[3:0], f[3:0], 1'b0)});
         end
      end
      load(4'b1000);
      drive(1'b1, 4'b1011, 2'b00, 4'b0000, 3'b000);
      #1 check("lt_n1v0", {3'b000, cond_ex0}, 4'b0001);
      drive(1'b1, 4'b1010, 2'b00, 4'b0000, 3'b000);
      #1 check("ge_n1v0", {3'b000, cond_ex0}, 4'b0000);
      load(4'b0010);
      drive(1'b1, 4'b1000, 2'b00, 4'b0000, 3'b000);
      #1 check("hi_c1z0", {3'b000, cond_ex0}, 4'b0001);
      drive(1'b1, 4'b1111, 2'b00, 4'b0000, 3'b000);
      #1 check("nv_param0", {3'b000, cond_ex0}, 4'b0000);
      check("nv_param1", {3'b000, cond_ex1}, 4'b0001);

      // stall
      load(4'b0101);
      drive(1'b0, 4'b1110, 2'b11, 4'b1010, 3'b111);
      #1 check("stall_gates", {1'b0, pc_src0, reg_write0, mem_write0}, 4'b0000);
      step();
      check("stall_hold", flags0, 4'b0101);
      en = 1'b1;
      step();
      check("stall_release", flags0, 4'b1010);

      // randomized traffic with occasional mid-cycle reset pulses
      for (int i = 0; i < 3000; i++) begin
         drive(1'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)),
               2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
               3'($urandom_range(0, 7)));
         if ($urandom_range(0, 199) == 0) begin
            #1 reset_n = 1'b0;
            #1 reset_n = 1'b1;
         end
         step();
      end

      cmp_on = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
